counter_modn: RTL and testbench

Parametrised modulo-N time-digit counter for the clock datapath. One counter serves the seconds, minutes and hours stages via MODULUS/WIDTH. Adds several things the fixed seconds counter lacks:
- up/down counting
- synchronised, edge-detected set buttons with increment and decrement
- parallel load with range check
- terminal-count and one-ahead look-ahead carries aligned to the count register

---
 rtl/clock_pkg.sv | 15 +
 rtl/button_edge_sync.sv | 34 +++
 rtl/counter_modn.sv | 117 +++++++++++
 tb/tb_counter_modn.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the clock datapath: per-stage moduli, widths and direction encodings.
package clock_pkg;

    localparam int unsigned SEC_MOD  = 60;
    localparam int unsigned MIN_MOD  = 60;
    localparam int unsigned HOUR_MOD = 24;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser for an asynchronous button, followed by a one-cycle rising-edge pulse.
module button_edge_sync (
    input  logic clock,
    input  logic reset_sec,
    input  logic btn,
    output logic pulse_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clock or posedge reset_sec) begin
        if (reset_sec) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // High for the single cycle in which the synchronised level first reads 1.
    assign pulse_c = sync2_q & ~prev_q;

endmodule

// File: rtl/counter_modn.sv
// Modulo-N up/down time-digit counter with set buttons, range-checked parallel load
// and registered terminal-count / look-ahead carries for cascading stages.
module counter_modn
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned MODULUS = 60
) (
    input  logic             clock,
    input  logic             reset_sec,
    input  logic             enable,
    input  logic             dir,
    input  logic             load_mode,
    input  logic             set_inc,
    input  logic             set_dec,
    input  logic             load_strobe,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count,
    output logic             carry_tc,
    output logic             carry_pre,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] PRE_UP  = WIDTH'(MODULUS - 2);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_tc_q, carry_tc_d;
    logic             carry_pre_q, carry_pre_d;
    logic             load_err_q, load_err_d;

    logic inc_pulse_c;
    logic dec_pulse_c;
    logic in_range_c;

    button_edge_sync u_inc_sync (
        .clock     (clock),
        .reset_sec (reset_sec),
        .btn       (set_inc),
        .pulse_c   (inc_pulse_c)
    );

    button_edge_sync u_dec_sync (
        .clock     (clock),
        .reset_sec (reset_sec),
        .btn       (set_dec),
        .pulse_c   (dec_pulse_c)
    );

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        return (v == MAX_C) ? '0 : v + ONE_C;
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        return (v == '0) ? MAX_C : v - ONE_C;
    endfunction

    // One extra bit so MODULUS == 2^WIDTH still compares correctly.
    assign in_range_c = ({1'b0, data_in} < MOD_EXT);

    // Next-state mux: load beats buttons, buttons beat ticks, ticks only outside setting.
    always_comb begin
        count_d     = count_q;
        load_err_d  = 1'b0;
        carry_tc_d  = 1'b0;
        carry_pre_d = 1'b0;

        if (load_mode) begin
            if (load_strobe) begin
                if (in_range_c) begin
                    count_d = data_in;
                end else begin
                    load_err_d = 1'b1;
                end
            end else if (inc_pulse_c && !dec_pulse_c) begin
                count_d = step_up(count_q);
            end else if (dec_pulse_c && !inc_pulse_c) begin
                count_d = step_down(count_q);
            end
        end else if (enable) begin
            count_d = (dir == DIR_DOWN) ? step_down(count_q) : step_up(count_q);
        end

        // Carries track the value count takes on this same edge.
        if (!load_mode) begin
            if (dir == DIR_DOWN) begin
                carry_tc_d  = (count_d == '0);
                carry_pre_d = (count_d == ONE_C);
            end else begin
                carry_tc_d  = (count_d == MAX_C);
                carry_pre_d = (count_d == PRE_UP);
            end
        end
    end

    always_ff @(posedge clock or posedge reset_sec) begin
        if (reset_sec) begin
            count_q     <= '0;
            carry_tc_q  <= 1'b0;
            carry_pre_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            carry_tc_q  <= carry_tc_d;
            carry_pre_q <= carry_pre_d;
            load_err_q  <= load_err_d;
        end
    end

    assign count     = count_q;
    assign carry_tc  = carry_tc_q;
    assign carry_pre = carry_pre_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_counter_modn.sv
// Directed bench: seconds/minutes/hours counters cascaded, checked against hand-computed values.
module tb_counter_modn;
    import clock_pkg::*;

    logic clock;
    logic reset_sec;
    logic load_mode;
    logic dir;
    logic tick;
    logic h_tick;
    logic set_inc;
    logic set_dec;
    logic s_ld, m_ld, h_ld;
    logic [SEC_W-1:0]  s_din;
    logic [MIN_W-1:0]  m_din;
    logic [HOUR_W-1:0] h_din;

    logic [SEC_W-1:0]  s_cnt;
    logic [MIN_W-1:0]  m_cnt;
    logic [HOUR_W-1:0] h_cnt;
    logic s_tc, s_pre, s_err;
    logic m_tc, m_pre, m_err;
    logic h_tc, h_pre, h_err;

    logic s_en, m_en, h_en;

    int tests_run;
    int tests_failed;

    assign s_en = tick;
    assign m_en = tick & s_tc;
    assign h_en = (tick & s_tc & m_tc) | h_tick;

    counter_modn #(.WIDTH(SEC_W), .MODULUS(SEC_MOD)) u_sec (
        .clock(clock), .reset_sec(reset_sec), .enable(s_en), .dir(dir),
        .load_mode(load_mode), .set_inc(set_inc), .set_dec(set_dec),
        .load_strobe(s_ld), .data_in(s_din), .count(s_cnt),
        .carry_tc(s_tc), .carry_pre(s_pre), .load_err(s_err)
    );

    counter_modn #(.WIDTH(MIN_W), .MODULUS(MIN_MOD)) u_min (
        .clock(clock), .reset_sec(reset_sec), .enable(m_en), .dir(dir),
        .load_mode(load_mode), .set_inc(set_inc), .set_dec(set_dec),
        .load_strobe(m_ld), .data_in(m_din), .count(m_cnt),
        .carry_tc(m_tc), .carry_pre(m_pre), .load_err(m_err)
    );

    counter_modn #(.WIDTH(HOUR_W), .MODULUS(HOUR_MOD)) u_hour (
        .clock(clock), .reset_sec(reset_sec), .enable(h_en), .dir(dir),
        .load_mode(load_mode), .set_inc(set_inc), .set_dec(set_dec),
        .load_strobe(h_ld), .data_in(h_din), .count(h_cnt),
        .carry_tc(h_tc), .carry_pre(h_pre), .load_err(h_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_sec = 1'b1;
        load_mode = 1'b0; dir = DIR_UP; tick = 1'b0; h_tick = 1'b0;
        set_inc = 1'b0; set_dec = 1'b0;
        s_ld = 1'b0; m_ld = 1'b0; h_ld = 1'b0;
        s_din = '0; m_din = '0; h_din = '0;

        step(2);
        check("rst_cnt",  32'(s_cnt), 0);
        check("rst_tc",   32'(s_tc),  0);
        check("rst_pre",  32'(s_pre), 0);
        check("rst_err",  32'(s_err), 0);
        #2 reset_sec = 1'b0;
        step(1);

        // Load range on the seconds stage
        load_mode = 1'b1; s_din = 6'd45; s_ld = 1'b1;
        step(1);
        check("load45_cnt", 32'(s_cnt), 45);
        check("load45_err", 32'(s_err), 0);
        s_din = 6'd60;
        step(1);
        check("load60_cnt", 32'(s_cnt), 45);
        check("load60_err", 32'(s_err), 1);
        s_ld = 1'b0;
        step(1);
        check("err_pulse_end", 32'(s_err), 0);
        load_mode = 1'b0; s_din = 6'd10; s_ld = 1'b1;
        step(1);
        check("ld_outside_cnt", 32'(s_cnt), 45);
        check("ld_outside_err", 32'(s_err), 0);
        s_ld = 1'b0;

        // Up wrap 57 -> 58 -> 59 -> 0
        load_mode = 1'b1; s_din = 6'd57; s_ld = 1'b1;
        step(1);
        s_ld = 1'b0; load_mode = 1'b0; dir = DIR_UP; tick = 1'b1;
        step(1);
        check("up58_cnt", 32'(s_cnt), 58);
        check("up58_pre", 32'(s_pre), 1);
        check("up58_tc",  32'(s_tc),  0);
        step(1);
        check("up59_cnt", 32'(s_cnt), 59);
        check("up59_pre", 32'(s_pre), 0);
        check("up59_tc",  32'(s_tc),  1);
        step(1);
        check("up0_cnt", 32'(s_cnt), 0);
        check("up0_pre", 32'(s_pre), 0);
        check("up0_tc",  32'(s_tc),  0);
        check("up0_min", 32'(m_cnt), 1);
        tick = 1'b0;

        // Down wrap on the hours stage (modulo 24)
        load_mode = 1'b1; h_din = 5'd1; h_ld = 1'b1;
        step(1);
        h_ld = 1'b0; load_mode = 1'b0; dir = DIR_DOWN;
        step(1);
        check("dn1_cnt", 32'(h_cnt), 1);
        check("dn1_pre", 32'(h_pre), 1);
        check("dn1_tc",  32'(h_tc),  0);
        check("dir_only_sec", 32'(s_cnt), 0);
        check("dir_only_tc",  32'(s_tc),  1);
        h_tick = 1'b1;
        step(1);
        check("dn0_cnt", 32'(h_cnt), 0);
        check("dn0_tc",  32'(h_tc),  1);
        check("dn0_pre", 32'(h_pre), 0);
        step(1);
        check("dn23_cnt", 32'(h_cnt), 23);
        check("dn23_tc",  32'(h_tc),  0);
        h_tick = 1'b0;

        // Set mode buttons on the seconds stage
        dir = DIR_UP; load_mode = 1'b1; s_din = 6'd59; s_ld = 1'b1;
        step(1);
        s_ld = 1'b0;
        check("set_tc_forced", 32'(s_tc), 0);
        set_inc = 1'b1;
        step(1);
        check("inc_edge1", 32'(s_cnt), 59);
        step(1);
        check("inc_edge2", 32'(s_cnt), 59);
        step(1);
        check("inc_edge3", 32'(s_cnt), 0);
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("inc_hold_cnt", 32'(s_cnt), 0);
            check("inc_hold_tc",  32'(s_tc),  0);
            check("inc_hold_pre", 32'(s_pre), 0);
        end
        set_inc = 1'b0;
        step(3);
        set_inc = 1'b1; set_dec = 1'b1;
        step(4);
        check("inc_dec_both", 32'(s_cnt), 0);
        set_inc = 1'b0; set_dec = 1'b0;
        step(3);
        set_dec = 1'b1;
        step(3);
        check("dec_wrap", 32'(s_cnt), 59);
        set_dec = 1'b0;
        step(3);

        // Button edges outside load_mode are dropped, not queued
        load_mode = 1'b0;
        step(1);
        set_inc = 1'b1;
        step(4);
        check("btn_outside_cnt", 32'(s_cnt), 59);
        check("btn_outside_tc",  32'(s_tc),  1);
        set_inc = 1'b0;
        step(3);
        load_mode = 1'b1;
        step(3);
        check("no_queued_edge", 32'(s_cnt), 59);

        // Cascade 00:59:59 -> 01:00:00
        s_din = 6'd59; m_din = 6'd59; h_din = 5'd0;
        s_ld = 1'b1; m_ld = 1'b1; h_ld = 1'b1;
        step(1);
        s_ld = 1'b0; m_ld = 1'b0; h_ld = 1'b0; load_mode = 1'b0;
        step(1);
        check("casc_s_tc", 32'(s_tc), 1);
        check("casc_m_tc", 32'(m_tc), 1);
        check("casc_h_cnt_pre", 32'(h_cnt), 0);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("casc_sec",  32'(s_cnt), 0);
        check("casc_min",  32'(m_cnt), 0);
        check("casc_hour", 32'(h_cnt), 1);

        // Asynchronous reset between edges
        load_mode = 1'b1; s_din = 6'd33; s_ld = 1'b1;
        step(1);
        s_din = 6'd60;
        step(1);
        s_ld = 1'b0;
        check("pre_rst_cnt", 32'(s_cnt), 33);
        check("pre_rst_err", 32'(s_err), 1);
        #1 reset_sec = 1'b1;
        #1;
        check("async_rst_cnt", 32'(s_cnt), 0);
        check("async_rst_err", 32'(s_err), 0);
        check("async_rst_tc",  32'(m_tc),  0);
        check("async_rst_min", 32'(m_cnt), 0);
        #1 reset_sec = 1'b0;
        load_mode = 1'b0; tick = 1'b1;
        step(1);
        check("resume1", 32'(s_cnt), 1);
        step(1);
        check("resume2", 32'(s_cnt), 2);
        tick = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
